// File: rtl/address_pack_pkg.sv
// Shared types and default sizes for the nibble-to-word address packer.
package address_pack_pkg;

    localparam int ADDR_DATA_W  = 16;
    localparam int ADDR_NIB_W   = 4;
    localparam int ADDR_NIBBLES = ADDR_DATA_W / ADDR_NIB_W;

    typedef enum logic [$clog2(ADDR_NIBBLES)-1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2,
        COL3 = 2'd3
    } col_state_e;

    // Drop one nibble into its MSB-first slot of a partially built word.
    function automatic logic [ADDR_DATA_W-1:0] place_nibble(
        input logic [ADDR_DATA_W-1:0] word,
        input int                     idx,
        input logic [ADDR_NIB_W-1:0]  nib
    );
        logic [ADDR_DATA_W-1:0] res;
        res = word;
        res[ADDR_DATA_W-1-idx*ADDR_NIB_W -: ADDR_NIB_W] = nib;
        return res;
    endfunction

endpackage

// File: rtl/address_pack_fsm_word_out_reg.sv
// One-entry valid/ready output register; a load and a drain in the same
// cycle replace the held word without a valid gap.
module word_out_reg #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         arst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Next-state for the held word and its valid flag.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output register with asynchronous clear.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/address_pack_fsm.sv
// Collects MSB-first nibbles into words and hands them out through a
// one-word valid/ready output buffer.
module address_pack_fsm
    import address_pack_pkg::*;
#(
    parameter int DATA_W  = ADDR_DATA_W,
    parameter int NIB_W   = ADDR_NIB_W,
    parameter int NIBBLES = DATA_W / NIB_W
) (
    input  logic              clk_i,
    input  logic              arst_ni,
    input  logic              clr_i,
    input  logic              data_i_valid_i,
    input  logic [NIB_W-1:0]  data_i,
    output logic              fsm_ready_o,
    input  logic              rec_ready_i,
    output logic              data_o_valid_o,
    output logic [DATA_W-1:0] data_o
);

    localparam int STATE_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [STATE_W-1:0] COL_FIRST = STATE_W'(0);
    localparam logic [STATE_W-1:0] COL_LAST  = STATE_W'(NIBBLES - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  placed_s;
    logic               accept_s;
    logic               load_s;

    // Only the last nibble can be blocked, and only by a stalled full output.
    assign fsm_ready_o = (state_q != COL_LAST) || !data_o_valid_o || rec_ready_i;
    assign accept_s    = data_i_valid_i && fsm_ready_o;

    // Collection state, shift content and word-load strobe.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        load_s   = 1'b0;
        placed_s = shift_q;
        placed_s[DATA_W-1-int'(state_q)*NIB_W -: NIB_W] = data_i;
        if (clr_i) begin
            state_d = COL_FIRST;
            shift_d = '0;
        end else if (accept_s) begin
            if (state_q == COL_LAST) begin
                state_d = COL_FIRST;
                shift_d = '0;
                load_s  = 1'b1;
            end else begin
                state_d = state_q + STATE_W'(1);
                shift_d = placed_s;
            end
        end else begin
            state_d = state_q;
            shift_d = shift_q;
        end
    end

    // Collection state and partial-word registers.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= COL_FIRST;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
        end
    end

    word_out_reg #(
        .W (DATA_W)
    ) u_word_out_reg (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .load_i      (load_s),
        .load_data_i (placed_s),
        .ready_i     (rec_ready_i),
        .valid_o     (data_o_valid_o),
        .data_o      (data_o)
    );

endmodule
